// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared definitions for the SPI slave responder: SPI mode
//            encodings, the responder state type, the default word width and
//            the edge-selection helpers used to turn CPOL/CPHA into
//            sample/shift strobes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_WORD_W = 16;

    // SelectMode encodings: [1] = CPOL, [0] = CPHA
    localparam logic [1:0] c_MODE0 = 2'b00;
    localparam logic [1:0] c_MODE1 = 2'b01;
    localparam logic [1:0] c_MODE2 = 2'b10;
    localparam logic [1:0] c_MODE3 = 2'b11;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Leading edge is the transition away from the idle level:
    // rising for CPOL=0, falling for CPOL=1. Passing ~cpol gives the
    // trailing edge.
    function automatic logic lead_edge(input logic cpol, input logic rise, input logic fall);
        return cpol ? fall : rise;
    endfunction

    // CPHA=0 samples on the leading edge; CPHA=1 on the trailing edge.
    function automatic logic sample_is_lead(input logic cpha);
        return ~cpha;
    endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Two-flop synchroniser for an asynchronous input plus a history
//            flop that yields single-cycle rise/fall pulses on clk.
// Ports    : clk      - system clock
//            RST      - synchronous active-high reset
//            d_i      - asynchronous input
//            q_o      - synchronised level
//            rise_o   - one-cycle pulse on a synchronised 0->1 transition
//            fall_o   - one-cycle pulse on a synchronised 1->0 transition
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic RST,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic r_meta_q;
    logic r_sync_q;
    logic r_hist_q;

    // Reset to the idle level of the line so leaving reset does not fake an edge
    always_ff @(posedge clk) begin
        if (RST) begin
            r_meta_q <= RST_VAL;
            r_sync_q <= RST_VAL;
            r_hist_q <= RST_VAL;
        end else begin
            r_meta_q <= d_i;
            r_sync_q <= r_meta_q;
            r_hist_q <= r_sync_q;
        end
    end

    assign q_o    = r_sync_q;
    assign rise_o = r_sync_q & ~r_hist_q;
    assign fall_o = ~r_sync_q & r_hist_q;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_responder
// Purpose  : SPI slave endpoint. Oversamples SCK/SS_n/MOSI on clk, collects
//            each WORD_W-bit frame as a read address, issues a one-cycle read
//            to a local memory port and returns the fetched word on MISO
//            during the following frame (ERR_WORD if it was not in time).
// Ports    : clk, RST            - system clock, sync active-high reset
//            SCK, SS_n, MOSI     - SPI inputs from the master (asynchronous)
//            SelectMode[1:0]     - {CPOL, CPHA}, static while selected
//            MISO, MISO_oe       - serial data out and its output enable
//            rd_req, rd_addr     - one-cycle read strobe and address
//            rd_data, rd_valid   - read return data and one-cycle valid
//            frame_done          - one-cycle pulse after the last sample edge
//            busy                - high while selected (ACTIVE)
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int                WORD_W   = c_WORD_W,
    parameter int                ADDR_W   = 10,
    parameter logic [WORD_W-1:0] ERR_WORD = {WORD_W{1'b1}}
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              SCK,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic [1:0]        SelectMode,
    output logic              MISO,
    output logic              MISO_oe,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int                 c_CNT_W    = $clog2(WORD_W);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WORD_W - 1);

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic w_sck_lvl, w_sck_rise, w_sck_fall;
    logic w_ss_lvl,  w_ss_rise,  w_ss_fall;
    logic w_mosi_s,  w_mosi_rise, w_mosi_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clk    (clk),
        .RST    (RST),
        .d_i    (SCK),
        .q_o    (w_sck_lvl),
        .rise_o (w_sck_rise),
        .fall_o (w_sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .clk    (clk),
        .RST    (RST),
        .d_i    (SS_n),
        .q_o    (w_ss_lvl),
        .rise_o (w_ss_rise),
        .fall_o (w_ss_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .RST    (RST),
        .d_i    (MOSI),
        .q_o    (w_mosi_s),
        .rise_o (w_mosi_rise),
        .fall_o (w_mosi_fall)
    );

    // ------------------------------------------------------------------
    // Edge decode
    // ------------------------------------------------------------------
    logic w_cpol, w_cpha;
    logic w_lead, w_trail, w_sample, w_shift;

    assign w_cpol   = SelectMode[1];
    assign w_cpha   = SelectMode[0];
    assign w_lead   = lead_edge(w_cpol,  w_sck_rise, w_sck_fall);
    assign w_trail  = lead_edge(~w_cpol, w_sck_rise, w_sck_fall);
    assign w_sample = sample_is_lead(w_cpha) ? w_lead  : w_trail;
    assign w_shift  = sample_is_lead(w_cpha) ? w_trail : w_lead;

    // ------------------------------------------------------------------
    // State machine: register / next-state / outputs
    // ------------------------------------------------------------------
    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_ss_fall) state_d = ACTIVE;
            ACTIVE:  if (w_ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [WORD_W-1:0] tx_shift_q, tx_shift_d;

    always_comb begin
        MISO    = 1'b0;
        MISO_oe = 1'b0;
        busy    = 1'b0;
        if (state_q == ACTIVE) begin
            MISO    = tx_shift_q[WORD_W-1];
            MISO_oe = 1'b1;
            busy    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WORD_W-2:0]  rx_shift_q, rx_shift_d;
    logic [WORD_W-1:0]  tx_next_q, tx_next_d;
    logic               pend_q, pend_d;      // a read is outstanding
    logic               hold_q, hold_d;      // CPHA=1: first leading edge presents bit MSB
    logic               reload_q, reload_d;  // frame wrapped: next shift edge reloads tx_shift
    logic               rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               frame_done_q, frame_done_d;

    logic [WORD_W-1:0]  w_rx_word;
    logic               w_enter, w_leave, w_active;
    logic               w_load;

    assign w_rx_word = {rx_shift_q, w_mosi_s};
    assign w_enter   = (state_q == IDLE)   && w_ss_fall;
    assign w_leave   = (state_q == ACTIVE) && w_ss_rise;
    // A sample edge coinciding with deselect is dropped: leaving has priority
    assign w_active  = (state_q == ACTIVE) && !w_ss_rise;

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        tx_next_d    = tx_next_q;
        pend_d       = pend_q;
        hold_d       = hold_q;
        reload_d     = reload_q;
        rd_req_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        frame_done_d = 1'b0;
        w_load       = 1'b0;

        if (w_enter) begin
            tx_shift_d = tx_next_q;
            w_load     = 1'b1;
            bit_cnt_d  = '0;
            hold_d     = w_cpha;
            reload_d   = 1'b0;
        end else if (w_leave) begin
            // Partial frame is abandoned; tx_next survives for the next select
            bit_cnt_d  = '0;
            hold_d     = 1'b0;
            reload_d   = 1'b0;
        end else if (w_active) begin
            if (w_sample) begin
                rx_shift_d = w_rx_word[WORD_W-2:0];
                if (bit_cnt_q == c_LAST_BIT) begin
                    bit_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    rd_req_d     = 1'b1;
                    rd_addr_d    = w_rx_word[ADDR_W-1:0];
                    reload_d     = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            if (w_shift) begin
                if (reload_q) begin
                    tx_shift_d = tx_next_q;
                    w_load     = 1'b1;
                    reload_d   = 1'b0;
                end else if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
                end
            end
        end

        // Once tx_shift has taken its word for the frame, any answer still
        // in flight is too late: retire the request so that answer is ignored.
        if (w_load) begin
            tx_next_d = ERR_WORD;
            pend_d    = 1'b0;
        end else if (rd_valid && pend_q) begin
            tx_next_d = rd_data;
            pend_d    = 1'b0;
        end

        if (rd_req_d) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= ERR_WORD;
            tx_next_q    <= ERR_WORD;
            pend_q       <= 1'b0;
            hold_q       <= 1'b0;
            reload_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            tx_next_q    <= tx_next_d;
            pend_q       <= pend_d;
            hold_q       <= hold_d;
            reload_q     <= reload_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign frame_done = frame_done_q;

    // Synchroniser outputs and upper received bits that carry no function here
    logic w_unused;
    assign w_unused = ^{w_rx_word[WORD_W-1:ADDR_W], w_mosi_rise, w_mosi_fall,
                        w_sck_lvl, w_ss_lvl};

endmodule : spi_slave_responder
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_responder
// Purpose  : Directed bench for spi_slave_responder. A bench SPI master drives
//            frames and pushes the expected read address and MISO word into
//            queues; a monitor pops and compares on rd_req and frame_done.
//            A bench memory answers read requests after a programmable delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_responder;

    localparam int HALF = 6;   // SCK half period in clk cycles

    logic        clk = 1'b0;
    logic        RST;
    logic        SCK;
    logic        SS_n;
    logic        MOSI;
    logic [1:0]  SelectMode;
    logic        MISO;
    logic        MISO_oe;
    logic        rd_req;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        frame_done;
    logic        busy;

    always #5 clk = ~clk;

    spi_slave_responder dut (
        .clk        (clk),
        .RST        (RST),
        .SCK        (SCK),
        .SS_n       (SS_n),
        .MOSI       (MOSI),
        .SelectMode (SelectMode),
        .MISO       (MISO),
        .MISO_oe    (MISO_oe),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    logic [15:0] mem [0:1023];
    logic [9:0]  q_addr [$];
    logic [15:0] q_miso [$];
    logic [15:0] last_rx;
    int          rd_delay = 1;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " MISO"},       32'(MISO),       32'h0);
        check({tag, " MISO_oe"},    32'(MISO_oe),    32'h0);
        check({tag, " rd_req"},     32'(rd_req),     32'h0);
        check({tag, " rd_addr"},    32'(rd_addr),    32'h0);
        check({tag, " frame_done"}, 32'(frame_done), 32'h0);
        check({tag, " busy"},       32'(busy),       32'h0);
    endtask

    // Bench memory: answers each rd_req after rd_delay cycles
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rd_req === 1'b1 && RST === 1'b0) begin
                logic [9:0] a;
                a = rd_addr;
                repeat (rd_delay) @(negedge clk);
                rd_data  = mem[a];
                rd_valid = 1'b1;
                @(negedge clk);
                rd_valid = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rd_req === 1'b1) begin
                if (q_addr.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected rd_req: got addr %h, expected no request (t=%0t)", rd_addr, $time);
                end else begin
                    logic [9:0] ea;
                    ea = q_addr.pop_front();
                    check("rd_addr", 32'(rd_addr), 32'(ea));
                end
            end
            if (frame_done === 1'b1) begin
                if (q_miso.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected frame_done: got pulse, expected none (t=%0t)", $time);
                end else begin
                    logic [15:0] em;
                    em = q_miso.pop_front();
                    check("MISO word", 32'(last_rx), 32'(em));
                end
            end
        end
    end

    // Bench SPI master. MOSI changes 2 clk after the shift edge so a slave
    // sampling on the wrong edge picks up the wrong bit.
    task automatic frame(input logic [15:0] w, input int nbits, input logic [15:0] exp_miso, input bit chk);
        logic [15:0] rx;
        logic        cpol;
        logic        cpha;
        rx   = '0;
        cpol = SelectMode[1];
        cpha = SelectMode[0];
        if (chk) begin
            q_miso.push_back(exp_miso);
            q_addr.push_back(w[9:0]);
        end
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                repeat (2) @(negedge clk);
                MOSI = w[15-i];
                repeat (HALF-2) @(negedge clk);
                rx = {rx[14:0], MISO};
                if (i == 15) last_rx = rx;
                SCK = ~cpol;
                repeat (HALF) @(negedge clk);
                SCK = cpol;
            end else begin
                SCK = ~cpol;
                repeat (2) @(negedge clk);
                MOSI = w[15-i];
                repeat (HALF-2) @(negedge clk);
                rx = {rx[14:0], MISO};
                if (i == 15) last_rx = rx;
                SCK = cpol;
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic sel();
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic desel();
        repeat (HALF) @(negedge clk);
        SS_n = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic set_mode(input logic [1:0] m);
        SelectMode = m;
        SCK        = m[1];
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h2AA] = 16'h1234;
        mem[10'h155] = 16'h5A5A;
        mem[10'h3FF] = 16'hBEEF;
        mem[10'h0C3] = 16'hC0DE;
        mem[10'h001] = 16'h0F0F;
        mem[10'h100] = 16'h8001;
        mem[10'h000] = 16'h7E81;
        last_rx    = '0;
        RST        = 1'b1;
        SCK        = 1'b0;
        SS_n       = 1'b1;
        MOSI       = 1'b0;
        SelectMode = 2'b00;
        repeat (5) @(negedge clk);
        check_reset("reset");
        RST = 1'b0;
        repeat (5) @(negedge clk);

        // 1: mode 0 back-to-back frames; first frame after reset is ERR_WORD
        set_mode(2'b00);
        sel();
        frame(16'hAAAA, 16, 16'hFFFF, 1'b1);
        frame(16'h5555, 16, 16'h1234, 1'b1);
        desel();

        // 2: modes 1..3
        set_mode(2'b01);
        sel();
        frame(16'h03FF, 16, 16'hFFFF, 1'b1);
        frame(16'h0000, 16, 16'hBEEF, 1'b1);
        desel();                      // CPHA=1: 0x7E81 still pending reload, kept
        set_mode(2'b10);
        sel();
        frame(16'h03FF, 16, 16'h7E81, 1'b1);
        frame(16'hFFFF, 16, 16'hBEEF, 1'b1);
        desel();
        set_mode(2'b11);
        sel();
        frame(16'h03FF, 16, 16'hFFFF, 1'b1);
        frame(16'h00C3, 16, 16'hBEEF, 1'b1);
        desel();                      // 0xC0DE kept

        // 3: late read data is dropped
        set_mode(2'b00);
        rd_delay = 20;
        sel();
        frame(16'h0001, 16, 16'hC0DE, 1'b1);
        frame(16'h0100, 16, 16'hFFFF, 1'b1);
        frame(16'h0000, 16, 16'hFFFF, 1'b1);
        desel();
        rd_delay = 1;
        repeat (20) @(negedge clk);

        // 4: abort after 7 bits, then full frames; tx_next kept over deselect
        set_mode(2'b01);
        sel();
        frame(16'h1234, 7, 16'h0000, 1'b0);
        check("busy before abort", 32'(busy), 32'h1);
        SS_n = 1'b1;
        repeat (4) @(negedge clk);
        check("MISO_oe after abort", 32'(MISO_oe), 32'h0);
        check("busy after abort",    32'(busy),    32'h0);
        check("MISO after abort",    32'(MISO),    32'h0);
        repeat (20) @(negedge clk);
        sel();
        frame(16'h0001, 16, 16'hFFFF, 1'b1);
        desel();
        sel();
        frame(16'h0100, 16, 16'h0F0F, 1'b1);
        desel();                      // 0x8001 kept

        // 5: reset at bit 9
        set_mode(2'b00);
        sel();
        frame(16'hF0F0, 9, 16'h0000, 1'b0);
        RST = 1'b1;
        @(negedge clk);
        check_reset("mid-frame reset");
        SS_n = 1'b1;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        repeat (10) @(negedge clk);
        sel();
        frame(16'h00C3, 16, 16'hFFFF, 1'b1);
        frame(16'h03FF, 16, 16'hC0DE, 1'b1);
        desel();

        // 6: SCK toggling while deselected
        for (int i = 0; i < 16; i++) begin
            SCK  = ~SCK;
            MOSI = ~MOSI;
            repeat (HALF) @(negedge clk);
            check("MISO_oe while deselected", 32'(MISO_oe), 32'h0);
        end

        repeat (50) @(negedge clk);
        check("pending rd_addr expectations", 32'(q_addr.size()), 32'h0);
        check("pending MISO expectations",    32'(q_miso.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_spi_slave_responder
`default_nettype wire
